// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
//   Definitions shared between the fetch stage and the IF/ID pipeline register:
//   datapath width, the NOP encoding, the default reset PC, the fetch FSM
//   state encoding and a PC increment helper.
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

    // Instruction and PC width shared with IF/ID
    localparam int XLEN = 32;

    // Instruction word presented to IF/ID when nothing valid is fetched
    localparam logic [XLEN-1:0] NOP_INST = '0;

    // Default program counter after reset
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Byte distance between consecutive instructions
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    // Sequential PC; wraps modulo 2^XLEN, no alignment check
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc_cur);
        return pc_cur + PC_STEP;
    endfunction

endpackage : if_fetch_stage_pkg

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage. Owns the PC, issues requests to a variable-latency
//   instruction memory and presents each fetched instruction with its PC+4 to
//   the IF/ID register. A response arriving while the hazard unit stalls is
//   buffered; a redirect arriving while a request is outstanding causes the
//   stale response to be waited out and discarded.
//
//   State | meaning
//   ------+---------------------------------------------------------------
//   FETCH | request at pc outstanding; response forwarded to IF/ID if free
//   HOLD  | response buffered in hold_inst while IF/ID is stalled
//   DROP  | stale request in flight; target saved in pend_pc until it lands
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   stall      in   hazard unit holds IF/ID
//   redirect   in   branch taken / jump resolved, wins over stall
//   redirectPC in   redirect target (used as given)
//   imemReq    out  request valid, address held until imemReady
//   imemAddr   out  fetch address
//   imemReady  in   one-cycle response pulse (may coincide with imemReq)
//   imemData   in   returned instruction
//   fetchValid out  instOut/pcPlus4Out carry a real instruction
//   instOut    out  instruction to IF/ID, NOP when not valid
//   pcPlus4Out out  PC+4 to IF/ID, 0 when not valid
// -----------------------------------------------------------------------------
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectPC,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemReady,
    input  logic [XLEN-1:0] imemData,
    output logic            fetchValid,
    output logic [XLEN-1:0] instOut,
    output logic [XLEN-1:0] pcPlus4Out
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] pend_pc_nxt;
    logic [XLEN-1:0] hold_inst;
    logic [XLEN-1:0] hold_inst_nxt;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc_inc(pc);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            pend_pc   <= '0;
            hold_inst <= NOP_INST;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            pend_pc   <= pend_pc_nxt;
            hold_inst <= hold_inst_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and next-PC select
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        pend_pc_nxt   = pend_pc;
        hold_inst_nxt = hold_inst;

        case (state)
            FETCH: begin
                if (imemReady) begin
                    if (redirect) begin
                        pc_nxt = redirectPC;
                    end else if (stall) begin
                        hold_inst_nxt = imemData;
                        state_nxt     = HOLD;
                    end else begin
                        pc_nxt = pc_plus4;
                    end
                end else if (redirect) begin
                    // The request at pc cannot be withdrawn; remember where
                    // to go once its response has been absorbed.
                    pend_pc_nxt = redirectPC;
                    state_nxt   = DROP;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirectPC;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    pc_nxt    = pc_plus4;
                    state_nxt = FETCH;
                end
            end

            DROP: begin
                if (redirect) begin
                    pend_pc_nxt = redirectPC;
                end
                if (imemReady) begin
                    // A redirect in the same cycle as the stale response is
                    // newer than anything already in pend_pc.
                    pc_nxt    = redirect ? redirectPC : pend_pc;
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. imemReq/imemAddr depend only on state and pc so the memory
    // never sees a combinational path from its own ready.
    // ------------------------------------------------------------------
    always_comb begin
        imemReq    = 1'b1;
        imemAddr   = pc;
        fetchValid = 1'b0;
        instOut    = NOP_INST;
        pcPlus4Out = '0;

        case (state)
            FETCH: begin
                if (imemReady && !redirect && !stall) begin
                    fetchValid = 1'b1;
                    instOut    = imemData;
                    pcPlus4Out = pc_plus4;
                end
            end

            HOLD: begin
                imemReq    = 1'b0;
                fetchValid = 1'b1;
                instOut    = hold_inst;
                pcPlus4Out = pc_plus4;
            end

            DROP: begin
                // stale address stays on the bus until its response lands
            end

            default: begin
            end
        endcase

        // Reset outputs are visible in the reset cycle itself, before the
        // registers have taken their reset values.
        if (rst) begin
            imemReq    = 1'b1;
            imemAddr   = RESET_PC;
            fetchValid = 1'b0;
            instOut    = NOP_INST;
            pcPlus4Out = '0;
        end
    end

endmodule : if_fetch_stage

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPC = 32'h0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b0;
    logic [31:0] imemData = 32'h0;
    logic        fetchValid;
    logic [31:0] instOut;
    logic [31:0] pcPlus4Out;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .redirect  (redirect),
        .redirectPC(redirectPC),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemReady (imemReady),
        .imemData  (imemData),
        .fetchValid(fetchValid),
        .instOut   (instOut),
        .pcPlus4Out(pcPlus4Out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what the fetch unit is doing in plain terms.
    logic [31:0] m_pc;       // address being requested / PC of held instruction
    logic [31:0] m_target;   // where to go once a stale response is absorbed
    logic [31:0] m_buf;      // instruction waiting for IF/ID
    bit          m_buffered; // an instruction is parked while IF/ID stalls
    bit          m_stale;    // outstanding request no longer wanted

    // Memory model: latency counted from the first cycle a request is seen.
    bit mb_busy;
    int mb_cnt;
    int mem_lat;             // fixed latency, or -1 for random 0..3

    logic        e_req, e_fv;
    logic [31:0] e_addr, e_inst, e_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [97:0] obs_vec();
        return {imemReq, (e_req ? imemAddr : 32'h0), fetchValid, instOut, pcPlus4Out};
    endfunction

    function automatic logic [97:0] exp_vec();
        return {e_req, (e_req ? e_addr : 32'h0), e_fv, e_inst, e_pc4};
    endfunction

    // Decide this cycle's memory response (called just after a rising edge).
    task automatic mem_phase();
        if (rst || m_buffered) begin
            imemReady = 1'b0;
        end else begin
            if (!mb_busy) begin
                mb_busy = 1'b1;
                mb_cnt  = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            end
            imemReady = (mb_cnt == 0);
        end
        imemData = imemReady ? mem_word(m_pc) : $urandom;
    endtask

    // Form expectations from the model and current inputs, then let logic settle.
    task automatic settle();
        e_req = 1'b1; e_addr = m_pc; e_fv = 1'b0; e_inst = 32'h0; e_pc4 = 32'h0;
        if (rst) begin
            e_addr = 32'h0;
        end else if (m_buffered) begin
            e_req = 1'b0; e_fv = 1'b1; e_inst = m_buf; e_pc4 = m_pc + 32'd4;
        end else if (!m_stale && imemReady && !redirect && !stall) begin
            e_fv = 1'b1; e_inst = imemData; e_pc4 = m_pc + 32'd4;
        end
        #1;
    endtask

    // Move the model across the rising edge and advance the clock.
    task automatic advance();
        if (rst) begin
            m_pc = 32'h0; m_target = 32'h0; m_buf = 32'h0;
            m_buffered = 1'b0; m_stale = 1'b0; mb_busy = 1'b0; mb_cnt = 0;
        end else begin
            if (m_buffered) begin
                if (redirect) begin
                    m_pc = redirectPC; m_buffered = 1'b0;
                end else if (!stall) begin
                    m_pc = m_pc + 32'd4; m_buffered = 1'b0;
                end
            end else if (m_stale) begin
                if (imemReady) begin
                    m_pc = redirect ? redirectPC : m_target; m_stale = 1'b0;
                end else if (redirect) begin
                    m_target = redirectPC;
                end
            end else if (imemReady) begin
                if (redirect) m_pc = redirectPC;
                else if (stall) begin m_buf = imemData; m_buffered = 1'b1; end
                else m_pc = m_pc + 32'd4;
            end else if (redirect) begin
                m_target = redirectPC; m_stale = 1'b1;
            end
            if (imemReady) mb_busy = 1'b0;
            else if (mb_busy) mb_cnt--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; imemReady = 1'b0;
        advance();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; mem_lat = 0;
        @(posedge clk); #1;
        advance();
        for (int i = 0; i < 3; i++) begin
            mem_phase();
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset: got %h want %h", obs_vec(), exp_vec());
            end
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        mem_lat = 0;
        for (int i = 0; i < 6; i++) begin
            mem_phase();
            stall = 1'b0; redirect = 1'b0;
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL zero_wait model: got %h want %h", obs_vec(), exp_vec());
            end
            if (i < 4) begin
                checks++;
                if (imemAddr !== 32'(i * 4) || fetchValid !== 1'b1 || pcPlus4Out !== 32'(i * 4 + 4)) begin
                    errors++;
                    $display("FAIL zero_wait seq%0d: addr %h fv %b pc4 %h want addr %h fv 1 pc4 %h",
                             i, imemAddr, fetchValid, pcPlus4Out, 32'(i * 4), 32'(i * 4 + 4));
                end
            end
            advance();
        end
    endtask

    task automatic test_stall_hold();
        int  hold_left = 0;
        bit  stalled = 0, released = 0, done = 0;
        quiet_reset();
        mem_lat = 2;
        for (int c = 0; c < 60 && !done; c++) begin
            mem_phase();
            redirect = 1'b0;
            if (!stalled && !m_buffered && m_pc == 32'h8 && imemReady) begin
                stalled = 1; hold_left = 4;
            end
            stall = (hold_left > 0);
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall_hold model: got %h want %h", obs_vec(), exp_vec());
            end
            if (released) begin
                checks++;
                if (imemReq !== 1'b1 || imemAddr !== 32'hC) begin
                    errors++;
                    $display("FAIL stall_next_req: req %b addr %h want req 1 addr 0000000c", imemReq, imemAddr);
                end
                done = 1;
            end else if (m_buffered) begin
                checks++;
                if (imemReq !== 1'b0 || instOut !== mem_word(32'h8) || fetchValid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold_out: req %b inst %h fv %b want req 0 inst %h fv 1",
                             imemReq, instOut, fetchValid, mem_word(32'h8));
                end
                if (!stall) begin
                    checks++;
                    if (pcPlus4Out !== 32'hC) begin
                        errors++;
                        $display("FAIL stall_release_pc4: got %h want 0000000c", pcPlus4Out);
                    end
                    released = 1;
                end
            end
            advance();
            if (hold_left > 0) hold_left--;
        end
        stall = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL stall_hold timeout: release sequence not observed");
        end
    endtask

    task automatic test_redirect_drop();
        bit fired = 0, done = 0;
        quiet_reset();
        mem_lat = 2;
        for (int c = 0; c < 100 && !done; c++) begin
            mem_phase();
            stall = 1'b0;
            redirect = 1'b0;
            if (fired && !m_stale) begin
                settle();
                checks++;
                if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin
                    errors++;
                    $display("FAIL drop_target: req %b addr %h want req 1 addr 00000100", imemReq, imemAddr);
                end
                done = 1;
            end else begin
                if (!fired && !m_stale && m_pc == 32'h20 && !imemReady) begin
                    redirect = 1'b1; redirectPC = 32'h100; fired = 1;
                end
                settle();
                if (m_stale) begin
                    checks++;
                    if (fetchValid !== 1'b0 || imemAddr !== 32'h20) begin
                        errors++;
                        $display("FAIL drop_discard: fv %b addr %h want fv 0 addr 00000020", fetchValid, imemAddr);
                    end
                end
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL redirect_drop model: got %h want %h", obs_vec(), exp_vec());
            end
            advance();
        end
        redirect = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL redirect_drop timeout: target fetch not observed");
        end
    endtask

    task automatic test_double_redirect();
        int phase = 0;
        quiet_reset();
        mem_lat = 3;
        for (int c = 0; c < 100 && phase < 6; c++) begin
            mem_phase();
            stall = 1'b0;
            redirect = 1'b0;
            case (phase)
                0: if (!m_stale && m_pc == 32'h10 && !imemReady) begin
                       redirect = 1'b1; redirectPC = 32'h100; phase = 1;
                   end
                1: begin redirect = 1'b1; redirectPC = 32'h200; phase = 2; end
                2: if (!m_stale) phase = 3;
                3: if (!imemReady) begin
                       redirect = 1'b1; redirectPC = 32'h300; phase = 4;
                   end
                4: if (imemReady) begin
                       redirect = 1'b1; redirectPC = 32'h400; phase = 5;
                   end
                default: phase = 6;
            endcase
            settle();
            if (phase == 3 && !redirect) begin
                checks++;
                if (imemAddr !== 32'h200) begin
                    errors++;
                    $display("FAIL double_latest: addr %h want 00000200", imemAddr);
                end
            end
            if (phase == 6) begin
                checks++;
                if (imemReq !== 1'b1 || imemAddr !== 32'h400) begin
                    errors++;
                    $display("FAIL coincident_redirect: req %b addr %h want req 1 addr 00000400", imemReq, imemAddr);
                end
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL double_redirect model: got %h want %h", obs_vec(), exp_vec());
            end
            advance();
        end
        redirect = 1'b0;
        if (phase < 6) begin
            errors++;
            $display("FAIL double_redirect timeout: phase %0d", phase);
        end
    endtask

    task automatic test_hold_redirect();
        int phase = 0;
        quiet_reset();
        mem_lat = 1;
        for (int c = 0; c < 40 && phase < 4; c++) begin
            mem_phase();
            stall = 1'b0;
            redirect = 1'b0;
            case (phase)
                0: if (imemReady) begin stall = 1'b1; phase = 1; end
                1: begin stall = 1'b1; redirect = 1'b1; redirectPC = 32'h80; phase = 2; end
                2: phase = 3;
                default: if (imemReady) phase = 4;
            endcase
            settle();
            if (phase == 3) begin
                checks++;
                if (imemReq !== 1'b1 || imemAddr !== 32'h80) begin
                    errors++;
                    $display("FAIL hold_redirect_req: req %b addr %h want req 1 addr 00000080", imemReq, imemAddr);
                end
            end
            if (phase == 4) begin
                checks++;
                if (fetchValid !== 1'b1 || instOut !== mem_word(32'h80) || pcPlus4Out !== 32'h84) begin
                    errors++;
                    $display("FAIL hold_redirect_data: fv %b inst %h pc4 %h want fv 1 inst %h pc4 00000084",
                             fetchValid, instOut, pcPlus4Out, mem_word(32'h80));
                end
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL hold_redirect model: got %h want %h", obs_vec(), exp_vec());
            end
            advance();
        end
        if (phase < 4) begin
            errors++;
            $display("FAIL hold_redirect timeout: phase %0d", phase);
        end
    endtask

    task automatic test_wrap_and_reset();
        quiet_reset();
        mem_lat = 0;
        for (int step = 0; step < 6; step++) begin
            rst = (step == 4);
            if (step == 2) mem_lat = 3;
            mem_phase();
            stall = 1'b0;
            redirect = (step == 0);
            redirectPC = 32'hFFFF_FFFC;
            settle();
            if (step == 1) begin
                checks++;
                if (imemAddr !== 32'hFFFF_FFFC || fetchValid !== 1'b1 || pcPlus4Out !== 32'h0) begin
                    errors++;
                    $display("FAIL wrap_pc4: addr %h fv %b pc4 %h want addr fffffffc fv 1 pc4 00000000",
                             imemAddr, fetchValid, pcPlus4Out);
                end
            end
            if (step == 2) begin
                checks++;
                if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
                    errors++;
                    $display("FAIL wrap_next: req %b addr %h want req 1 addr 00000000", imemReq, imemAddr);
                end
            end
            if (step == 5) begin
                checks++;
                if (imemAddr !== 32'h0 || fetchValid !== 1'b0 || imemReq !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_reset: req %b addr %h fv %b want req 1 addr 00000000 fv 0",
                             imemReq, imemAddr, fetchValid);
                end
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_reset model step%0d: got %h want %h", step, obs_vec(), exp_vec());
            end
            advance();
        end
        rst = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic test_random();
        quiet_reset();
        mem_lat = -1;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            mem_phase();
            stall = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 99) < 12);
            redirectPC = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 255)) << 2);
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            advance();
        end
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_hold();
        test_redirect_drop();
        test_double_redirect();
        test_hold_redirect();
        test_wrap_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_if_fetch_stage
